sprite_multi_obstacle_core: RTL and testbench

- Parametrised multi-sprite overlay core that sits in the video stream chain as a slot of the video controller.
- Draws N_SPR independent obstacle sprites from a shared multi-frame 2-bit bitmap over the incoming stream.
- Adds per-sprite hardware motion with screen wrap, a shared 3-colour palette, fixed priority, and sticky pairwise collision flags readable by the CPU.

---
 rtl/sprite_multi_obstacle_core.sv | 239 +++++++++++++++++++++++
 tb/tb_sprite_multi_obstacle_core.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_multi_obstacle_core.sv
`default_nettype none
// ============================================================================
// Module   : sprite_multi_obstacle_core
// Purpose  : Video-slot overlay drawing N_SPR obstacle sprites from a shared
//            multi-frame 2-bit bitmap, with per-sprite wrap-around motion,
//            a 3-colour palette, fixed priority (lowest index wins) and
//            sticky W1C collision flags.
// Options  : SPRITE_ANIM_EN - per-sprite frame animation driven by the
//            motion tick (undefined: frame changes only via CPU writes).
// Revision : 1.0 - initial release
// ============================================================================
module sprite_multi_obstacle_core #(
  parameter int CD          = 12,
  parameter int N_SPR       = 4,
  parameter int N_FRAMES    = 2,
  parameter int SIZE_LOG2   = 5,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int MOTION_LINE = 480,
  parameter int ANIM_DIV    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic          read,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  localparam int FB    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 0;
  localparam int FA    = FB + 2 * SIZE_LOG2;
  localparam int DEPTH = 1 << FA;
  localparam logic signed [11:0] H_MOD = 12'(H_RES);
  localparam logic signed [11:0] V_MOD = 12'(V_RES);

  logic wr_en, bmp_we, spr_we, glb_we, tick;
  logic unused_bits;

  logic [N_SPR-1:0][3:0]  ctrl_all;
  logic [N_SPR-1:0][10:0] x0_all;
  logic [N_SPR-1:0][10:0] y0_all;
  logic [N_SPR-1:0][7:0]  vel_all;
  logic [N_SPR-1:0][1:0]  code;
  logic [N_SPR-1:0]       opaque;
  logic                   multi;
  logic [1:0]             win_code;
  logic [CD-1:0]          pal_color;
  logic [31:0]            rd_next;

  logic                   bypass;
  logic [CD-1:0]          pal1, pal2, pal3;
  logic [N_SPR-1:0]       coll;
  logic [CD-1:0]          rgb_d1;

  assign wr_en  = cs & write;
  assign bmp_we = wr_en & ~addr[13];
  assign spr_we = wr_en & (addr[13:12] == 2'b10);
  assign glb_we = wr_en & (addr[13:12] == 2'b11) & (addr[11:3] == 9'd0);
  assign tick   = (x == 11'd0) && (y == 11'(MOTION_LINE));
  assign unused_bits = ^wr_data;

  // Position + signed velocity, wrapped once into [0, mod)
  function automatic logic [10:0] wrap_step(input logic [10:0] pos,
                                            input logic [3:0]  d,
                                            input logic signed [11:0] m);
    logic signed [11:0] n;
    n = signed'({1'b0, pos}) + signed'({{8{d[3]}}, d});
    if (n[11])       n = n + m;
    else if (n >= m) n = n - m;
    return n[10:0];
  endfunction

  for (genvar i = 0; i < N_SPR; i++) begin : g_spr
    logic [3:0]    ctrl_q;
    logic [10:0]   x0_q, y0_q;
    logic [7:0]    vel_q;
    logic          slot_we;
    logic [10:0]   dxo, dyo;
    logic [FA-1:0] raddr;
    logic [1:0]    bmp [DEPTH];
    logic [1:0]    pix_q;
    logic          hit_q;
`ifdef SPRITE_ANIM_EN
    logic [2:0]    anim_cnt;
    logic [1:0]    next_frame;
    assign next_frame = 2'((int'(ctrl_q[2:1]) + 1) % N_FRAMES);
`endif

    assign slot_we = spr_we && (addr[6:3] == 4'(i));
    assign dxo     = x - x0_q;
    assign dyo     = y - y0_q;
    assign raddr   = FA'((int'(ctrl_q[2:1]) % N_FRAMES) << (2 * SIZE_LOG2))
                   | FA'({dyo[SIZE_LOG2-1:0], dxo[SIZE_LOG2-1:0]});

    // Sprite registers: tick updates first so a same-cycle CPU write overrides
    always_ff @(posedge clk) begin
      if (reset) begin
        ctrl_q <= '0;
        x0_q   <= '0;
        y0_q   <= '0;
        vel_q  <= '0;
`ifdef SPRITE_ANIM_EN
        anim_cnt <= '0;
`endif
      end else begin
        if (tick) begin
          x0_q <= wrap_step(x0_q, vel_q[3:0], H_MOD);
          y0_q <= wrap_step(y0_q, vel_q[7:4], V_MOD);
`ifdef SPRITE_ANIM_EN
          if (ctrl_q[3]) begin
            if (anim_cnt == 3'(ANIM_DIV - 1)) begin
              anim_cnt    <= '0;
              ctrl_q[2:1] <= next_frame;
            end else begin
              anim_cnt <= anim_cnt + 3'd1;
            end
          end
`endif
        end
        if (slot_we) begin
          case (addr[2:0])
            3'd0:    ctrl_q <= wr_data[3:0];
            3'd1:    x0_q   <= wr_data[10:0];
            3'd2:    y0_q   <= wr_data[10:0];
            3'd3:    vel_q  <= wr_data[7:0];
            default: ;
          endcase
        end
      end
    end

    // Private bitmap copy; all copies take every write so each has a read port
    always_ff @(posedge clk) begin
      if (bmp_we) bmp[addr[FA-1:0]] <= wr_data[1:0];
    end

    // Stage 1: unsigned-offset hit test and bitmap fetch
    always_ff @(posedge clk) begin
      if (reset) begin
        hit_q <= 1'b0;
        pix_q <= 2'b00;
      end else begin
        hit_q <= ctrl_q[0] && (dxo[10:SIZE_LOG2] == '0) && (dyo[10:SIZE_LOG2] == '0);
        pix_q <= bmp[raddr];
      end
    end

    assign code[i]     = hit_q ? pix_q : 2'b00;
    assign opaque[i]   = |code[i];
    assign ctrl_all[i] = ctrl_q;
    assign x0_all[i]   = x0_q;
    assign y0_all[i]   = y0_q;
    assign vel_all[i]  = vel_q;
  end

  assign multi = |(opaque & (opaque - N_SPR'(1)));

  // Priority pick: scanning downwards leaves the lowest opaque index
  always_comb begin
    win_code = 2'b00;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (code[i] != 2'b00) win_code = code[i];
    end
  end

  // Palette lookup for the winning code
  always_comb begin
    case (win_code)
      2'd1:    pal_color = pal1;
      2'd2:    pal_color = pal2;
      default: pal_color = pal3;
    endcase
  end

  // CPU read mux; anything unmapped (including the bitmap) reads zero
  always_comb begin
    rd_next = '0;
    if (addr[13:12] == 2'b10) begin
      for (int i = 0; i < N_SPR; i++) begin
        if (addr[6:3] == 4'(i)) begin
          case (addr[2:0])
            3'd0:    rd_next = 32'(ctrl_all[i]);
            3'd1:    rd_next = 32'(x0_all[i]);
            3'd2:    rd_next = 32'(y0_all[i]);
            3'd3:    rd_next = 32'(vel_all[i]);
            default: ;
          endcase
        end
      end
    end else if (addr[13:12] == 2'b11 && addr[11:3] == 9'd0) begin
      case (addr[2:0])
        3'd0:    rd_next = 32'(bypass);
        3'd1:    rd_next = 32'(pal1);
        3'd2:    rd_next = 32'(pal2);
        3'd3:    rd_next = 32'(pal3);
        3'd4:    rd_next = 32'(coll);
        default: ;
      endcase
    end
  end

  // Stage 2 output, global registers, collision flags and read data
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_d1  <= '0;
      so_rgb  <= '0;
      bypass  <= 1'b0;
      pal1    <= '0;
      pal2    <= '0;
      pal3    <= '0;
      coll    <= '0;
      rd_data <= '0;
    end else begin
      rgb_d1 <= si_rgb;
      so_rgb <= (bypass || win_code == 2'b00) ? rgb_d1 : pal_color;
      if (glb_we) begin
        case (addr[2:0])
          3'd0:    bypass <= wr_data[0];
          3'd1:    pal1   <= wr_data[CD-1:0];
          3'd2:    pal2   <= wr_data[CD-1:0];
          3'd3:    pal3   <= wr_data[CD-1:0];
          default: ;
        endcase
      end
      // A new collision in the same cycle as a W1C clear keeps the bit set
      coll <= (coll & ~((glb_we && addr[2:0] == 3'd4) ? wr_data[N_SPR-1:0] : '0))
            | (multi ? opaque : '0);
      if (cs && read) rd_data <= rd_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_multi_obstacle_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_multi_obstacle_core
// Purpose  : Directed self-checking bench for sprite_multi_obstacle_core with
//            a queue scoreboard (expected pushed at drive, popped at output).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_multi_obstacle_core;

  localparam logic [10:0] IDLE_X = 11'd500;
  localparam logic [10:0] IDLE_Y = 11'd300;
  localparam logic [13:0] SPR    = 14'h2000;
  localparam logic [13:0] GLB    = 14'h3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x, y;
  logic        cs, write, read;
  logic [13:0] addr;
  logic [31:0] wr_data, rd_data;
  logic [11:0] si_rgb, so_rgb;
  logic [31:0] anim_frame1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  sprite_multi_obstacle_core dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .cs(cs), .write(write), .read(read), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data),
    .si_rgb(si_rgb), .so_rgb(so_rgb)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] sreg(int s, int r);
    return SPR | 14'(s * 8 + r);
  endfunction

  function automatic logic [13:0] bm(int f, int row, int col);
    return 14'(f * 1024 + row * 32 + col);
  endfunction

  task automatic push(string tag, logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wr(logic [13:0] a, logic [31:0] d);
    @(negedge clk); cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(negedge clk); cs = 1'b0; write = 1'b0;
  endtask

  task automatic rd(logic [13:0] a, logic [31:0] e, string tag);
    @(negedge clk); cs = 1'b1; read = 1'b1; addr = a; push(tag, e);
    @(negedge clk); cs = 1'b0; read = 1'b0; pop_check(rd_data);
  endtask

  task automatic pix(logic [10:0] px, logic [10:0] py, logic [11:0] si,
                     logic [11:0] e, string tag);
    @(negedge clk); x = px; y = py; si_rgb = si; push(tag, 32'(e));
    @(negedge clk); x = IDLE_X; y = IDLE_Y; si_rgb = '0;
    @(negedge clk); pop_check(32'(so_rgb));
  endtask

  task automatic tick();
    @(negedge clk); x = 11'd0; y = 11'd480;
    @(negedge clk); x = IDLE_X; y = IDLE_Y;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; x = IDLE_X; y = IDLE_Y; cs = 1'b0; write = 1'b0; read = 1'b0;
    addr = '0; wr_data = '0; si_rgb = '0;
`ifdef SPRITE_ANIM_EN
    anim_frame1 = 32'hB;
`else
    anim_frame1 = 32'h9;
`endif
    repeat (3) @(negedge clk);
    push("reset_so_rgb", 32'h0);  pop_check(32'(so_rgb));
    push("reset_rd_data", 32'h0); pop_check(rd_data);

    // release reset with a pixel already presented
    reset = 1'b0; x = 11'd100; y = 11'd100; si_rgb = 12'h0F0;
    push("flush_so_rgb", 32'h0);
    push("passthru_latency2", 32'h0F0);
    @(negedge clk); pop_check(32'(so_rgb));
    x = IDLE_X; y = IDLE_Y; si_rgb = '0;
    @(negedge clk); pop_check(32'(so_rgb));

    rd(sreg(0, 0), 32'h0, "rd_ctrl0_reset");
    rd(sreg(0, 1), 32'h0, "rd_x0_reset");
    rd(GLB | 14'd1, 32'h0, "rd_pal1_reset");
    rd(GLB | 14'd4, 32'h0, "rd_coll_reset");

    // sprite 0 with a few known bitmap pixels
    wr(bm(0, 0, 0), 32'h1);
    wr(bm(0, 0, 1), 32'h0);
    wr(bm(0, 31, 31), 32'h3);
    wr(GLB | 14'd1, 32'hF00);
    wr(GLB | 14'd3, 32'h0AB);
    wr(sreg(0, 1), 32'd100);
    wr(sreg(0, 2), 32'd100);
    wr(sreg(0, 0), 32'h1);
    rd(bm(0, 0, 0), 32'h0, "rd_bitmap_zero");
    pix(11'd100, 11'd100, 12'h0F0, 12'hF00, "spr0_hit");
    pix(11'd99,  11'd100, 12'h0F0, 12'h0F0, "spr0_left_miss");
    pix(11'd100, 11'd99,  12'h0F0, 12'h0F0, "spr0_above_miss");
    pix(11'd101, 11'd100, 12'h0F0, 12'h0F0, "spr0_transparent");
    pix(11'd131, 11'd131, 12'h0F0, 12'h0AB, "spr0_corner");
    pix(11'd132, 11'd131, 12'h0F0, 12'h0F0, "spr0_right_miss");

    // sprite 1 on frame 1, overlapping sprite 0
    wr(bm(1, 0, 0), 32'h2);
    wr(GLB | 14'd2, 32'h00F);
    wr(sreg(1, 1), 32'd100);
    wr(sreg(1, 2), 32'd100);
    wr(sreg(1, 0), 32'h3);
    rd(sreg(1, 0), 32'h3, "rd_ctrl1");
    pix(11'd100, 11'd100, 12'h0F0, 12'hF00, "priority_spr0");
    rd(GLB | 14'd4, 32'h3, "coll_both");
    wr(GLB | 14'd4, 32'h1);
    rd(GLB | 14'd4, 32'h2, "coll_w1c");
    wr(sreg(0, 0), 32'h0);
    pix(11'd100, 11'd100, 12'h0F0, 12'h00F, "spr1_alone_frame1");
    rd(GLB | 14'd4, 32'h2, "coll_sticky");
    wr(GLB | 14'd4, 32'hF);
    rd(GLB | 14'd4, 32'h0, "coll_clear");

    // new collision lands on the same edge as a W1C clear
    wr(sreg(0, 0), 32'h1);
    @(negedge clk); x = 11'd100; y = 11'd100; si_rgb = 12'h0F0;
    @(negedge clk); x = IDLE_X; y = IDLE_Y; si_rgb = '0;
    cs = 1'b1; write = 1'b1; addr = GLB | 14'd4; wr_data = 32'h3;
    @(negedge clk); cs = 1'b0; write = 1'b0;
    rd(GLB | 14'd4, 32'h3, "coll_set_beats_clear");

    // bypass hides sprites but collisions still record
    wr(GLB | 14'd4, 32'h3);
    wr(GLB | 14'd0, 32'h1);
    pix(11'd100, 11'd100, 12'h123, 12'h123, "bypass_pixel");
    rd(GLB | 14'd4, 32'h3, "coll_in_bypass");
    rd(GLB | 14'd0, 32'h1, "rd_bypass");
    wr(GLB | 14'd0, 32'h0);

    // unmapped locations
    wr(sreg(5, 1), 32'd77);
    rd(sreg(5, 1), 32'h0, "unmapped_slot");
    rd(sreg(0, 5), 32'h0, "unmapped_reg");
    rd(GLB | 14'd7, 32'h0, "unmapped_glb");

    // motion with wrap, including a disabled sprite
    wr(sreg(0, 1), 32'd638);
    wr(sreg(0, 3), 32'h03);
    wr(sreg(2, 1), 32'd10);
    wr(sreg(2, 3), 32'h05);
    tick();
    rd(sreg(0, 1), 32'd1, "wrap_right");
    rd(sreg(0, 2), 32'd100, "y_static");
    wr(sreg(0, 2), 32'd1);
    wr(sreg(0, 3), 32'hEC);
    tick();
    rd(sreg(0, 1), 32'd637, "wrap_left");
    rd(sreg(0, 2), 32'd479, "wrap_top");
    @(negedge clk); x = 11'd0; y = 11'd480;
    cs = 1'b1; write = 1'b1; addr = sreg(0, 1); wr_data = 32'd50;
    @(negedge clk); x = IDLE_X; y = IDLE_Y; cs = 1'b0; write = 1'b0;
    rd(sreg(0, 1), 32'd50, "cpu_beats_tick");
    rd(sreg(0, 2), 32'd477, "tick_other_reg");
    rd(sreg(2, 1), 32'd25, "motion_disabled_spr");

    // animation: frame advances only when the feature is built in
    wr(sreg(0, 3), 32'h0);
    wr(sreg(0, 0), 32'h9);
    repeat (7) tick();
    rd(sreg(0, 0), 32'h9, "anim_7_ticks");
    tick();
    rd(sreg(0, 0), anim_frame1, "anim_8_ticks");
    repeat (8) tick();
    rd(sreg(0, 0), 32'h9, "anim_16_ticks");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
